// File: rtl/mem_port_arbiter_if.sv
// Purpose: signal bundle between the IF/DM clients, the port arbiter and the unified memory.
// Latency: none, wires only.
// Backpressure: requests are held by the client until gnt; rvalid/rdata are unconditional pulses.
// Modports: slave = arbiter view (drives gnt/rvalid/rdata and the memory strobe/address/data),
//           master = client + memory view (drives requests and mem_rdata).
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  // instruction-fetch port
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  // data port
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_gnt;
  logic              dm_rvalid;
  logic [DATA_W-1:0] dm_rdata;
  // unified memory
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Purpose: shares one fixed-latency single-ported memory between the IF and DM ports, DM first.
// Latency: grant and mem_en in the request cycle t; rvalid with registered rdata at t+MEM_LAT+1.
// Backpressure: one transaction in flight; requests wait (no gnt) until IDLE or RESP.
// Ports: clk, reset (synchronous, active-high), bus (slave modport: IF/DM request and
//        response signals plus the memory strobe/address/data and mem_rdata return).
module mem_port_arbiter #(
  parameter int ADDR_W      = 64,
  parameter int DATA_W      = 64,
  parameter int MEM_LAT     = 1,
  parameter int MAX_DSTREAK = 4
) (
  input  logic              clk,
  input  logic              reset,
  mem_port_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);
  localparam int STK_W = $clog2(MAX_DSTREAK + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [STK_W-1:0]  streak;
  logic              owner_dm;   // 1: transaction in flight belongs to DM
  logic              owner_we;   // in-flight DM transaction is a write
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] dm_rdata_q;

  logic              win_dm;
  logic              win_if;
  logic [ADDR_W-1:0] addr_mux;
  logic [DATA_W-1:0] wdata_mux;

  // Arbitration and next state. Reset masks the grant so nothing is
  // handed out in a cycle whose state update is about to be discarded.
  always_comb begin
    state_nxt = state;
    win_dm    = 1'b0;
    win_if    = 1'b0;
    if (!reset && (state != WAIT)) begin
      // DM wins ties unless IF has already been passed over MAX_DSTREAK times
      win_dm = bus.dm_req && (!bus.if_req || (streak != STK_W'(MAX_DSTREAK)));
      win_if = bus.if_req && !win_dm;
    end
    case (state)
      IDLE, RESP: state_nxt = (win_dm || win_if) ? WAIT : IDLE;
      WAIT:       if (cnt == '0) state_nxt = RESP;
      default:    state_nxt = IDLE;
    endcase
  end

  // Memory request is steered straight from the winner in the grant cycle.
  always_comb begin
    addr_mux  = '0;
    wdata_mux = '0;
    if (win_dm) begin
      addr_mux  = bus.dm_addr;
      wdata_mux = bus.dm_wdata;
    end else if (win_if) begin
      addr_mux  = bus.if_addr;
    end
  end

  assign bus.if_gnt    = win_if;
  assign bus.dm_gnt    = win_dm;
  assign bus.mem_en    = win_dm || win_if;
  assign bus.mem_we    = win_dm && bus.dm_we;
  assign bus.mem_addr  = addr_mux;
  assign bus.mem_wdata = wdata_mux;

  assign bus.if_rvalid = (state == RESP) && !owner_dm && !reset;
  assign bus.dm_rvalid = (state == RESP) &&  owner_dm && !reset;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rdata  = dm_rdata_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      streak     <= '0;
      owner_dm   <= 1'b0;
      owner_we   <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state <= state_nxt;

      if (win_dm || win_if) begin
        owner_dm <= win_dm;
        owner_we <= win_dm && bus.dm_we;
        cnt      <= CNT_W'(MEM_LAT - 1);
        // streak only grows while IF is actually being held off
        if (win_dm && bus.if_req) begin
          if (streak != STK_W'(MAX_DSTREAK)) streak <= streak + STK_W'(1);
        end else begin
          streak <= '0;
        end
      end else if ((state == WAIT) && (cnt != '0)) begin
        cnt <= cnt - CNT_W'(1);
      end

      // Last WAIT cycle: memory data is valid now. Write acks return zero.
      if ((state == WAIT) && (cnt == '0)) begin
        if (owner_dm) dm_rdata_q <= owner_we ? '0 : bus.mem_rdata;
        else          if_rdata_q <= bus.mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic clk;
  logic rst1;
  logic rst3;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_port_arbiter_if #(.ADDR_W(64), .DATA_W(64)) b1 ();
  mem_port_arbiter_if #(.ADDR_W(64), .DATA_W(64)) b3 ();

  mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(1), .MAX_DSTREAK(4)) u_dut1 (
    .clk   (clk),
    .reset (rst1),
    .bus   (b1)
  );

  mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(3), .MAX_DSTREAK(4)) u_dut3 (
    .clk   (clk),
    .reset (rst3),
    .bus   (b3)
  );

  // ---------------- memory models ----------------
  function automatic logic [63:0] init_val(input logic [63:0] a);
    case (a)
      64'h10:  return 64'hAA;
      64'h30:  return 64'h1122_3344_5566_7788;
      64'h40:  return 64'h1234;
      64'h50:  return 64'h5050;
      default: return 64'h0;
    endcase
  endfunction

  localparam logic [63:0] BAD_DATA = 64'h0BAD_0BAD_0BAD_0BAD;

  logic [63:0] mem1 [16];
  bit   [15:0] wr1;
  logic        p1_v = 1'b0;
  logic [63:0] p1_d;

  always @(posedge clk) begin
    if (b1.mem_en && b1.mem_we) begin
      mem1[b1.mem_addr[6:3]] <= b1.mem_wdata;
      wr1[b1.mem_addr[6:3]]  <= 1'b1;
    end
    p1_v <= b1.mem_en && !b1.mem_we;
    p1_d <= wr1[b1.mem_addr[6:3]] ? mem1[b1.mem_addr[6:3]] : init_val(b1.mem_addr);
  end
  assign b1.mem_rdata = p1_v ? p1_d : BAD_DATA;

  logic [63:0] mem3 [16];
  bit   [15:0] wr3;
  logic [2:0]  p3_v = 3'b000;
  logic [63:0] p3_d [3];

  always @(posedge clk) begin
    if (b3.mem_en && b3.mem_we) begin
      mem3[b3.mem_addr[6:3]] <= b3.mem_wdata;
      wr3[b3.mem_addr[6:3]]  <= 1'b1;
    end
    p3_v    <= {p3_v[1:0], b3.mem_en && !b3.mem_we};
    p3_d[0] <= wr3[b3.mem_addr[6:3]] ? mem3[b3.mem_addr[6:3]] : init_val(b3.mem_addr);
    p3_d[1] <= p3_d[0];
    p3_d[2] <= p3_d[1];
  end
  assign b3.mem_rdata = p3_v[2] ? p3_d[2] : BAD_DATA;

  // ---------------- observation ----------------
  typedef struct packed {
    logic        if_gnt;
    logic        if_rvalid;
    logic        dm_gnt;
    logic        dm_rvalid;
    logic        mem_en;
    logic        mem_we;
    logic [63:0] if_rdata;
    logic [63:0] dm_rdata;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
  } obs_t;

  obs_t o1;
  obs_t o3;
  assign o1 = {b1.if_gnt, b1.if_rvalid, b1.dm_gnt, b1.dm_rvalid, b1.mem_en, b1.mem_we,
               b1.if_rdata, b1.dm_rdata, b1.mem_addr, b1.mem_wdata};
  assign o3 = {b3.if_gnt, b3.if_rvalid, b3.dm_gnt, b3.dm_rvalid, b3.mem_en, b3.mem_we,
               b3.if_rdata, b3.dm_rdata, b3.mem_addr, b3.mem_wdata};

  function automatic obs_t obs(input int which);
    return (which == 1) ? o1 : o3;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // ---------------- scoreboard ----------------
  typedef struct {
    bit          dm;
    logic [63:0] rdata;
    int          due;
  } sb_t;

  sb_t q1[$];
  sb_t q3[$];

  task automatic push(input int which, input bit dm, input logic [63:0] rd);
    sb_t e;
    e.dm    = dm;
    e.rdata = rd;
    e.due   = cyc + ((which == 1) ? 2 : 4);
    if (which == 1) q1.push_back(e);
    else            q3.push_back(e);
  endtask

  task automatic mon(input int which);
    obs_t o;
    sb_t  e;
    o = obs(which);
    if (o.if_rvalid || o.dm_rvalid) begin
      chk($sformatf("rsp_onehot_d%0d", which), 64'(o.if_rvalid & o.dm_rvalid), 64'd0);
      if (((which == 1) ? q1.size() : q3.size()) == 0) begin
        fail($sformatf("rsp_unexpected_d%0d", which));
      end else begin
        e = (which == 1) ? q1.pop_front() : q3.pop_front();
        chk($sformatf("rsp_port_d%0d", which), 64'(o.dm_rvalid), 64'(e.dm));
        chk($sformatf("rsp_data_d%0d", which), o.dm_rvalid ? o.dm_rdata : o.if_rdata, e.rdata);
        chk($sformatf("rsp_cycle_d%0d", which), 64'(cyc), 64'(e.due));
      end
    end
  endtask

  always @(negedge clk) if (!rst1) mon(1);
  always @(negedge clk) if (!rst3) mon(3);

  // ---------------- stimulus helpers ----------------
  task automatic drive(input int which, input bit dm, input bit req, input bit we,
                       input logic [63:0] addr, input logic [63:0] wdata);
    if (which == 1) begin
      if (dm) begin b1.dm_req = req; b1.dm_we = we; b1.dm_addr = addr; b1.dm_wdata = wdata; end
      else    begin b1.if_req = req; b1.if_addr = addr; end
    end else begin
      if (dm) begin b3.dm_req = req; b3.dm_we = we; b3.dm_addr = addr; b3.dm_wdata = wdata; end
      else    begin b3.if_req = req; b3.if_addr = addr; end
    end
  endtask

  task automatic chk_zero(input int which, input string tag);
    obs_t o;
    o = obs(which);
    chk({tag, "_ctl"}, 64'({o.if_gnt, o.if_rvalid, o.dm_gnt, o.dm_rvalid, o.mem_en, o.mem_we}), 64'd0);
    chk({tag, "_if_rdata"}, o.if_rdata, 64'd0);
    chk({tag, "_dm_rdata"}, o.dm_rdata, 64'd0);
    chk({tag, "_mem_addr"}, o.mem_addr, 64'd0);
    chk({tag, "_mem_wdata"}, o.mem_wdata, 64'd0);
  endtask

  // One transaction: request, wait (bounded) for the grant, check the memory
  // strobe in the grant cycle, queue the expected response, drop the request.
  task automatic do_txn(input int which, input bit dm, input bit we, input logic [63:0] addr,
                        input logic [63:0] wdata, input logic [63:0] exp_rd);
    obs_t o;
    bit   got;
    got = 1'b0;
    @(posedge clk); #1;
    drive(which, dm, 1'b1, we, addr, wdata);
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      o = obs(which);
      if (dm ? o.dm_gnt : o.if_gnt) begin
        got = 1'b1;
        chk("txn_other_gnt", 64'(dm ? o.if_gnt : o.dm_gnt), 64'd0);
        chk("txn_mem_en", 64'(o.mem_en), 64'd1);
        chk("txn_mem_we", 64'(o.mem_we), 64'(dm & we));
        chk("txn_mem_addr", o.mem_addr, addr);
        chk("txn_mem_wdata", o.mem_wdata, dm ? wdata : 64'd0);
        push(which, dm, exp_rd);
      end
      @(posedge clk); #1;
    end
    drive(which, dm, 1'b0, 1'b0, 64'd0, 64'd0);
    if (!got) fail("txn_grant_timeout");
    repeat ((which == 1) ? 2 : 4) @(posedge clk);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    bit          dm;
    bit          we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] exp_rd;
  } vec_t;

  vec_t tbl [8];

  initial begin
    int   n;
    bit   exp_dm;

    tbl[0] = '{1'b0, 1'b0, 64'h10, 64'h0,                   64'hAA};
    tbl[1] = '{1'b1, 1'b1, 64'h08, 64'h55,                  64'h0};
    tbl[2] = '{1'b1, 1'b0, 64'h08, 64'h0,                   64'h55};
    tbl[3] = '{1'b0, 1'b0, 64'h08, 64'h0,                   64'h55};
    tbl[4] = '{1'b1, 1'b1, 64'h20, 64'hDEAD_BEEF_CAFE_F00D, 64'h0};
    tbl[5] = '{1'b0, 1'b0, 64'h20, 64'h0,                   64'hDEAD_BEEF_CAFE_F00D};
    tbl[6] = '{1'b1, 1'b0, 64'h30, 64'h0,                   64'h1122_3344_5566_7788};
    tbl[7] = '{1'b1, 1'b1, 64'h30, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0};

    rst1 = 1'b1;
    rst3 = 1'b1;
    drive(1, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
    drive(1, 1'b1, 1'b0, 1'b0, 64'd0, 64'd0);
    drive(3, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
    drive(3, 1'b1, 1'b0, 1'b0, 64'd0, 64'd0);

    // reset: everything zero, even with requests pending
    repeat (2) @(posedge clk);
    #1;
    drive(1, 1'b0, 1'b1, 1'b0, 64'h10, 64'd0);
    drive(3, 1'b1, 1'b1, 1'b0, 64'h40, 64'd0);
    @(negedge clk);
    chk_zero(1, "reset_d1");
    chk_zero(3, "reset_d3");
    @(posedge clk); #1;
    drive(1, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
    drive(3, 1'b1, 1'b0, 1'b0, 64'd0, 64'd0);
    rst1 = 1'b0;
    rst3 = 1'b0;

    // single transactions, MEM_LAT=1
    for (int i = 0; i < 8; i++)
      do_txn(1, tbl[i].dm, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].exp_rd);

    // rdata registers keep the last capture per port
    @(negedge clk);
    chk("hold_if_rdata", o1.if_rdata, 64'hDEAD_BEEF_CAFE_F00D);
    chk("hold_dm_rdata", o1.dm_rdata, 64'h0);

    // simultaneous requests: DM first, IF granted in DM's RESP cycle
    @(posedge clk); #1;
    drive(1, 1'b1, 1'b1, 1'b0, 64'h10, 64'd0);
    drive(1, 1'b0, 1'b1, 1'b0, 64'h20, 64'd0);
    @(negedge clk);
    chk("both_t0_dm_gnt", 64'(o1.dm_gnt), 64'd1);
    chk("both_t0_if_gnt", 64'(o1.if_gnt), 64'd0);
    push(1, 1'b1, 64'hAA);
    @(posedge clk); #1;
    drive(1, 1'b1, 1'b0, 1'b0, 64'd0, 64'd0);
    @(negedge clk);
    chk("both_t1_gnt", 64'({o1.if_gnt, o1.dm_gnt}), 64'd0);
    @(negedge clk);
    chk("both_t2_if_gnt", 64'(o1.if_gnt), 64'd1);
    push(1, 1'b0, 64'hDEAD_BEEF_CAFE_F00D);
    @(posedge clk); #1;
    drive(1, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
    repeat (4) @(posedge clk);

    // both held: D,D,D,D,I repeating
    #1;
    drive(1, 1'b1, 1'b1, 1'b0, 64'h08, 64'd0);
    drive(1, 1'b0, 1'b1, 1'b0, 64'h10, 64'd0);
    n = 0;
    for (int c = 0; c < 60 && n < 10; c++) begin
      @(negedge clk);
      if (o1.dm_gnt || o1.if_gnt) begin
        exp_dm = ((n % 5) != 4);
        chk($sformatf("streak_grant%0d_is_dm", n), 64'(o1.dm_gnt), 64'(exp_dm));
        chk("streak_gnt_onehot", 64'(o1.dm_gnt & o1.if_gnt), 64'd0);
        push(1, exp_dm, exp_dm ? 64'h55 : 64'hAA);
        n++;
      end
      @(posedge clk); #1;
    end
    drive(1, 1'b1, 1'b0, 1'b0, 64'd0, 64'd0);
    drive(1, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
    chk("streak_grant_count", 64'(n), 64'd10);
    repeat (4) @(posedge clk);

    // MEM_LAT=3 DM read, IF waits through WAIT and is granted in RESP
    #1;
    drive(3, 1'b1, 1'b1, 1'b0, 64'h40, 64'd0);
    @(negedge clk);
    chk("lat3_dm_gnt", 64'(o3.dm_gnt), 64'd1);
    push(3, 1'b1, 64'h1234);
    @(posedge clk); #1;
    drive(3, 1'b1, 1'b0, 1'b0, 64'd0, 64'd0);
    drive(3, 1'b0, 1'b1, 1'b0, 64'h50, 64'd0);
    for (int k = 1; k <= 3; k++) begin
      if (k > 1) @(posedge clk);
      @(negedge clk);
      chk($sformatf("lat3_wait%0d_quiet", k), 64'({o3.if_gnt, o3.dm_gnt, o3.mem_en}), 64'd0);
    end
    @(negedge clk);
    chk("lat3_if_gnt_in_resp", 64'(o3.if_gnt), 64'd1);
    push(3, 1'b0, 64'h5050);
    @(posedge clk); #1;
    drive(3, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
    repeat (8) @(posedge clk);

    // reset in the middle of WAIT drops the transaction
    #1;
    drive(3, 1'b1, 1'b1, 1'b0, 64'h40, 64'd0);
    @(negedge clk);
    chk("rstwait_dm_gnt", 64'(o3.dm_gnt), 64'd1);
    @(posedge clk); #1;
    drive(3, 1'b1, 1'b0, 1'b0, 64'd0, 64'd0);
    @(posedge clk); #1;
    rst3 = 1'b1;
    @(posedge clk); #1;
    rst3 = 1'b0;
    @(negedge clk);
    chk_zero(3, "rstwait");
    repeat (5) @(posedge clk);
    do_txn(3, 1'b0, 1'b0, 64'h50, 64'd0, 64'h5050);

    repeat (8) @(posedge clk);
    chk("drain_d1", 64'(q1.size()), 64'd0);
    chk("drain_d3", 64'(q3.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
